// File: rtl/m1resetreq.sv
// m1resetreq: reset request controller.
// Merges a debounced pushbutton, a keyed software reset register and an
// optional watchdog into a single trigger_reset pulse. The cause of the last
// request is kept in a CAUSE register that survives sys_rst_n.
// Build option: define M1RESETREQ_WDT_EN to include the watchdog. Without it,
// WDT_LOAD/WDT_CTRL read 0 and ignore writes, and CAUSE bit2 stays 0.
module m1resetreq #(
  parameter logic [3:0]  CSR_ADDR        = 4'h0,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
  parameter logic [7:0]  PULSE_LEN       = 8'd16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        btn_reset_n,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        trigger_reset,
  output logic [2:0]  reset_cause
);

  localparam logic [31:0] SWRST_KEY  = 32'hC0DE0001;
  localparam logic [7:0]  KICK_KEY   = 8'h5A;
  localparam logic [19:0] DEB_LAST   = DEBOUNCE_CYCLES - 20'd1;
  localparam logic [7:0]  PULSE_LAST = PULSE_LEN - 8'd1;

  localparam logic [1:0] ADDR_SWRST    = 2'd0;
  localparam logic [1:0] ADDR_WDT_LOAD = 2'd1;
  localparam logic [1:0] ADDR_WDT_CTRL = 2'd2;
  localparam logic [1:0] ADDR_CAUSE    = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // CSR decode
  // ---------------------------------------------------------------------
  logic       bank_sel;
  logic [1:0] word_addr;
  logic       wr_swrst;
  logic       wr_cause;
  logic       sw_req;
  logic       unused_addr_bits;

  assign bank_sel  = (csr_a[13:10] == CSR_ADDR);
  assign word_addr = csr_a[1:0];
  assign wr_swrst  = csr_we && bank_sel && (word_addr == ADDR_SWRST);
  assign wr_cause  = csr_we && bank_sel && (word_addr == ADDR_CAUSE);
  // Only the exact key raises a request; anything else is silently dropped.
  assign sw_req    = wr_swrst && (csr_di == SWRST_KEY);
  // Address bits between bank select and word address are don't-care.
  assign unused_addr_bits = ^csr_a[9:2];

  // ---------------------------------------------------------------------
  // Pushbutton: two-flop synchronizer plus saturating debounce counter
  // ---------------------------------------------------------------------
  logic [1:0]  btn_sync_reg;
  logic        btn_level;
  logic [19:0] deb_cnt_reg;
  logic        btn_req_reg;

  assign btn_level = btn_sync_reg[1];

  // Bring the asynchronous button into the sys_clk domain.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      btn_sync_reg <= 2'b00;
    end else begin
      btn_sync_reg <= {btn_sync_reg[0], btn_reset_n};
    end
  end

  // Count consecutive low samples; a single high sample restarts the count.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      deb_cnt_reg <= 20'd0;
    end else if (btn_level) begin
      deb_cnt_reg <= 20'd0;
    end else if (deb_cnt_reg != DEB_LAST) begin
      deb_cnt_reg <= deb_cnt_reg + 20'd1;
    end
  end

  // Button request holds while the counter sits at its last value and the
  // button is still low; it drops together with the first high sample.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      btn_req_reg <= 1'b0;
    end else begin
      btn_req_reg <= !btn_level && (deb_cnt_reg == DEB_LAST);
    end
  end

  // ---------------------------------------------------------------------
  // Request merge and FSM handshake signals
  // ---------------------------------------------------------------------
  state_t     state_reg;
  logic [7:0] pulse_cnt_reg;
  logic       trigger_reg;
  logic       wdt_req;
  logic       any_req;
  logic       pulse_entry;

  assign any_req     = btn_req_reg | sw_req | wdt_req;
  // Requests are only honoured from IDLE; later ones are dropped.
  assign pulse_entry = sys_rst_n && (state_reg == IDLE) && any_req;

  // ---------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------
  logic [31:0] wdt_load_rd;
  logic        wdt_en_rd;

`ifdef M1RESETREQ_WDT_EN
  logic        wr_load;
  logic        wr_ctrl;
  logic        wdt_kick;
  logic        wdt_start;
  logic        wdt_reload;
  logic [31:0] wdt_load_reg;
  logic [31:0] wdt_cnt_reg;
  logic        wdt_en_reg;
  logic        wdt_req_reg;

  assign wr_load    = csr_we && bank_sel && (word_addr == ADDR_WDT_LOAD);
  assign wr_ctrl    = csr_we && bank_sel && (word_addr == ADDR_WDT_CTRL);
  assign wdt_kick   = wr_ctrl && (csr_di[15:8] == KICK_KEY);
  // Turning the watchdog on starts a fresh timeout interval.
  assign wdt_start  = wr_ctrl && csr_di[0] && !wdt_en_reg;
  assign wdt_reload = wdt_kick || wdt_start;

  // Countdown, expiry and enable bookkeeping. Later assignments win: expiry
  // overrides a plain enable write, and pulse entry overrides everything.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wdt_load_reg <= 32'hFFFF_FFFF;
      wdt_cnt_reg  <= 32'd0;
      wdt_en_reg   <= 1'b0;
      wdt_req_reg  <= 1'b0;
    end else begin
      wdt_req_reg <= 1'b0;
      if (wr_load) begin
        wdt_load_reg <= csr_di;
      end
      if (wr_ctrl) begin
        wdt_en_reg <= csr_di[0];
      end
      if (wdt_reload) begin
        // A kick coinciding with expiry wins: reload, no request.
        wdt_cnt_reg <= wdt_load_reg;
      end else if (wdt_en_reg) begin
        if (wdt_cnt_reg == 32'd0) begin
          wdt_req_reg <= 1'b1;
          wdt_en_reg  <= 1'b0;
        end else begin
          wdt_cnt_reg <= wdt_cnt_reg - 32'd1;
        end
      end
      if (pulse_entry) begin
        wdt_en_reg <= 1'b0;
      end
    end
  end

  assign wdt_req     = wdt_req_reg;
  assign wdt_load_rd = wdt_load_reg;
  assign wdt_en_rd   = wdt_en_reg;
`else
  assign wdt_req     = 1'b0;
  assign wdt_load_rd = 32'd0;
  assign wdt_en_rd   = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // CAUSE register: no sys_rst_n term so it survives the reset it causes
  // ---------------------------------------------------------------------
  logic [2:0] cause_reg = 3'b000;
  logic [2:0] cause_set;
  logic [2:0] cause_clr;
  logic [2:0] cause_next;

  assign cause_set = pulse_entry ? {wdt_req, sw_req, btn_req_reg} : 3'b000;
  // Clears are ignored while the system is held in reset.
  assign cause_clr = (wr_cause && sys_rst_n) ? csr_di[2:0] : 3'b000;

  // Per-bit write-1-to-clear; a new source setting the bit wins over a clear.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cause
      assign cause_next[gi] = cause_set[gi] | (cause_reg[gi] & ~cause_clr[gi]);
    end
  endgenerate

  // Capture the source bits; deliberately no reset branch.
  always_ff @(posedge sys_clk) begin
    cause_reg <= cause_next;
  end

  assign reset_cause = cause_reg;

  // ---------------------------------------------------------------------
  // Pulse FSM
  // ---------------------------------------------------------------------
  // IDLE waits for a request, PULSE drives trigger_reset for PULSE_LEN
  // cycles, HOLD waits for the button to be let go before re-arming.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_reg     <= IDLE;
      pulse_cnt_reg <= 8'd0;
      trigger_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          trigger_reg <= 1'b0;
          if (any_req) begin
            state_reg     <= PULSE;
            pulse_cnt_reg <= PULSE_LAST;
            trigger_reg   <= 1'b1;
          end
        end
        PULSE: begin
          if (pulse_cnt_reg == 8'd0) begin
            state_reg   <= HOLD;
            trigger_reg <= 1'b0;
          end else begin
            pulse_cnt_reg <= pulse_cnt_reg - 8'd1;
            trigger_reg   <= 1'b1;
          end
        end
        HOLD: begin
          trigger_reg <= 1'b0;
          if (!btn_req_reg) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg   <= IDLE;
          trigger_reg <= 1'b0;
        end
      endcase
    end
  end

  assign trigger_reset = trigger_reg;

  // ---------------------------------------------------------------------
  // CSR read port: registered, zero when the bank does not match
  // ---------------------------------------------------------------------
  // Read data one cycle after the address.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      csr_do <= 32'd0;
    end else if (!bank_sel) begin
      csr_do <= 32'd0;
    end else begin
      case (word_addr)
        ADDR_SWRST:    csr_do <= 32'd0;
        ADDR_WDT_LOAD: csr_do <= wdt_load_rd;
        ADDR_WDT_CTRL: csr_do <= {31'd0, wdt_en_rd};
        ADDR_CAUSE:    csr_do <= {29'd0, cause_reg};
        default:       csr_do <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_m1resetreq.sv
// Directed testbench for m1resetreq (DEBOUNCE_CYCLES=8, PULSE_LEN=16).
// Inputs change and outputs are sampled on the falling edge of sys_clk.
module tb_m1resetreq;

  localparam logic [3:0]  BANK = 4'h0;
  localparam logic [19:0] DEB  = 20'd8;
  localparam logic [7:0]  PL   = 8'd16;
  localparam logic [31:0] KEY  = 32'hC0DE0001;

  logic        sys_clk     = 1'b0;
  logic        sys_rst_n   = 1'b0;
  logic        btn_reset_n = 1'b1;
  logic [13:0] csr_a       = 14'd0;
  logic        csr_we      = 1'b0;
  logic [31:0] csr_di      = 32'd0;
  logic [31:0] csr_do;
  logic        trigger_reset;
  logic [2:0]  reset_cause;

  int checks = 0;
  int errors = 0;

  m1resetreq #(
    .CSR_ADDR(BANK),
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_LEN(PL)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .btn_reset_n(btn_reset_n),
    .csr_a(csr_a),
    .csr_we(csr_we),
    .csr_di(csr_di),
    .csr_do(csr_do),
    .trigger_reset(trigger_reset),
    .reset_cause(reset_cause)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic csr_write(input logic [1:0] addr, input logic [31:0] data);
    csr_a  = {BANK, 8'h00, addr};
    csr_di = data;
    csr_we = 1'b1;
    @(negedge sys_clk);
    csr_we = 1'b0;
    csr_di = 32'd0;
    $display("csr write addr=%0d data=%h", addr, data);
  endtask

  task automatic csr_read(input logic [1:0] addr, output logic [31:0] data);
    csr_a  = {BANK, 8'h00, addr};
    csr_we = 1'b0;
    @(negedge sys_clk);
    data = csr_do;
    $display("csr read  addr=%0d data=%h", addr, data);
  endtask

  // Count high cycles starting at the current (high) sample, bounded.
  task automatic measure_pulse(output int len);
    len = 0;
    while (trigger_reset === 1'b1 && len < 40) begin
      len++;
      step(1);
    end
    $display("pulse measured len=%0d", len);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    int bad;
    sys_rst_n = 1'b0;
    step(3);
    checks++;
    if (trigger_reset !== 1'b0) begin
      errors++;
      $display("FAIL reset_trigger got=%b exp=0", trigger_reset);
    end
    checks++;
    if (csr_do !== 32'd0) begin
      errors++;
      $display("FAIL reset_csr_do got=%h exp=0", csr_do);
    end
    sys_rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (trigger_reset !== 1'b0 || csr_do !== 32'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet bad_cycles=%0d exp=0", bad);
    end
    csr_read(2'd3, d);
    checks++;
    if (d !== 32'd0 || reset_cause !== 3'b000) begin
      errors++;
      $display("FAIL poweron_cause got=%h/%b exp=0", d, reset_cause);
    end
    csr_read(2'd1, d);
    checks++;
`ifdef M1RESETREQ_WDT_EN
    if (d !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_wdt_load got=%h exp=ffffffff", d);
    end
`else
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL reset_wdt_load got=%h exp=0", d);
    end
`endif
    // Other bank: must read 0.
    csr_a = {4'h1, 8'h00, 2'd1};
    step(1);
    checks++;
    if (csr_do !== 32'd0) begin
      errors++;
      $display("FAIL other_bank_read got=%h exp=0", csr_do);
    end
  endtask

  task automatic test_button;
    logic [31:0] d;
    int bad;
    int len;
    // Short press: 5 low cycles is below the 8-sample debounce.
    btn_reset_n = 1'b0;
    step(5);
    btn_reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (trigger_reset !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL btn_short_press bad_cycles=%0d exp=0", bad);
    end
    // Long press: pulse must rise exactly 2+8+1 = 11 cycles after the fall.
    btn_reset_n = 1'b0;
    bad = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (trigger_reset !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL btn_early_rise bad_cycles=%0d exp=0", bad);
    end
    step(1);
    checks++;
    if (trigger_reset !== 1'b1) begin
      errors++;
      $display("FAIL btn_rise_at_11 got=%b exp=1", trigger_reset);
    end
    measure_pulse(len);
    checks++;
    if (len != 16) begin
      errors++;
      $display("FAIL btn_pulse_len got=%0d exp=16", len);
    end
    // Button still held: HOLD must not retrigger.
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (trigger_reset !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL btn_hold_no_retrigger bad_cycles=%0d exp=0", bad);
    end
    btn_reset_n = 1'b1;
    step(5);
    csr_read(2'd3, d);
    checks++;
    if (d !== 32'd1 || reset_cause !== 3'b001) begin
      errors++;
      $display("FAIL btn_cause got=%h/%b exp=1/001", d, reset_cause);
    end
    csr_write(2'd3, 32'd1);
    csr_read(2'd3, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL btn_cause_clear got=%h exp=0", d);
    end
  endtask

  task automatic test_swrst;
    logic [31:0] d;
    int bad;
    int len;
    csr_write(2'd0, 32'hC0DE0002);
    bad = (trigger_reset !== 1'b0) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (trigger_reset !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sw_bad_key bad_cycles=%0d exp=0", bad);
    end
    // Correct key in another bank: ignored.
    csr_a  = {4'h2, 8'h00, 2'd0};
    csr_di = KEY;
    csr_we = 1'b1;
    step(1);
    csr_we = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (trigger_reset !== 1'b0) bad++;
      step(1);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sw_wrong_bank bad_cycles=%0d exp=0", bad);
    end
    csr_write(2'd0, KEY);
    checks++;
    if (trigger_reset !== 1'b1) begin
      errors++;
      $display("FAIL sw_rise got=%b exp=1", trigger_reset);
    end
    measure_pulse(len);
    checks++;
    if (len != 16) begin
      errors++;
      $display("FAIL sw_pulse_len got=%0d exp=16", len);
    end
    step(3);
    csr_read(2'd0, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL swrst_reads_zero got=%h exp=0", d);
    end
    csr_read(2'd3, d);
    checks++;
    if (d !== 32'd2) begin
      errors++;
      $display("FAIL sw_cause got=%h exp=2", d);
    end
    csr_write(2'd3, 32'd2);
    csr_read(2'd3, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL sw_cause_clear got=%h exp=0", d);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    int len;
    // Button request first visible in IDLE 11 edges after the fall; the SW
    // write is sampled on that same edge.
    btn_reset_n = 1'b0;
    step(10);
    csr_write(2'd0, KEY);
    checks++;
    if (trigger_reset !== 1'b1) begin
      errors++;
      $display("FAIL both_rise got=%b exp=1", trigger_reset);
    end
    measure_pulse(len);
    checks++;
    if (len != 16) begin
      errors++;
      $display("FAIL both_pulse_len got=%0d exp=16", len);
    end
    checks++;
    if (reset_cause !== 3'b011) begin
      errors++;
      $display("FAIL both_cause got=%b exp=011", reset_cause);
    end
    btn_reset_n = 1'b1;
    step(5);
    csr_write(2'd3, 32'd3);
    csr_read(2'd3, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL both_cause_clear got=%h exp=0", d);
    end
  endtask

  task automatic test_reset_mid_pulse;
    logic [31:0] d;
    int bad;
    int len;
    csr_write(2'd0, KEY);
    step(2);
    checks++;
    if (trigger_reset !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pulse_cycle3 got=%b exp=1", trigger_reset);
    end
    sys_rst_n = 1'b0;
    step(1);
    checks++;
    if (trigger_reset !== 1'b0) begin
      errors++;
      $display("FAIL midrst_drop got=%b exp=0", trigger_reset);
    end
    checks++;
    if (reset_cause !== 3'b010) begin
      errors++;
      $display("FAIL midrst_cause_kept got=%b exp=010", reset_cause);
    end
    sys_rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (trigger_reset !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrst_no_resume bad_cycles=%0d exp=0", bad);
    end
    // FSM is back in IDLE: a new request gives a full pulse.
    csr_write(2'd0, KEY);
    measure_pulse(len);
    checks++;
    if (len != 16) begin
      errors++;
      $display("FAIL midrst_rearm_len got=%0d exp=16", len);
    end
    step(3);
    csr_write(2'd3, 32'd7);
    csr_read(2'd3, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL midrst_cause_clear got=%h exp=0", d);
    end
  endtask

`ifdef M1RESETREQ_WDT_EN
  task automatic test_wdt;
    logic [31:0] d;
    int bad;
    int len;
    csr_write(2'd1, 32'd10);
    csr_read(2'd1, d);
    checks++;
    if (d !== 32'd10) begin
      errors++;
      $display("FAIL wdt_load_rw got=%h exp=a", d);
    end
    csr_write(2'd2, 32'h1);
    step(8);
    csr_write(2'd2, 32'h0000_5A01);
    // Counter reloaded to 10: expiry 11 edges later, trigger one after.
    bad = 0;
    for (int i = 1; i <= 11; i++) begin
      step(1);
      if (trigger_reset !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wdt_early bad_cycles=%0d exp=0", bad);
    end
    step(1);
    checks++;
    if (trigger_reset !== 1'b1) begin
      errors++;
      $display("FAIL wdt_rise_at_12 got=%b exp=1", trigger_reset);
    end
    measure_pulse(len);
    checks++;
    if (len != 16) begin
      errors++;
      $display("FAIL wdt_pulse_len got=%0d exp=16", len);
    end
    step(2);
    csr_read(2'd3, d);
    checks++;
    if (d !== 32'd4) begin
      errors++;
      $display("FAIL wdt_cause got=%h exp=4", d);
    end
    csr_read(2'd2, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL wdt_enable_cleared got=%h exp=0", d);
    end
    csr_write(2'd3, 32'd4);
  endtask
`else
  task automatic test_wdt;
    logic [31:0] d;
    int bad;
    csr_write(2'd1, 32'd10);
    csr_read(2'd1, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL nowdt_load_read got=%h exp=0", d);
    end
    csr_write(2'd2, 32'h1);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (trigger_reset !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL nowdt_no_expiry bad_cycles=%0d exp=0", bad);
    end
    csr_read(2'd2, d);
    checks++;
    if (d !== 32'd0 || reset_cause !== 3'b000) begin
      errors++;
      $display("FAIL nowdt_ctrl_read got=%h/%b exp=0/000", d, reset_cause);
    end
  endtask
`endif

  initial begin
    @(negedge sys_clk);
    test_reset();
    test_button();
    test_swrst();
    test_back_to_back();
    test_reset_mid_pulse();
    test_wdt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit reached");
  end

endmodule
